branch_predictor_table: RTL

- Parametrised successor of the 2-bit branch history table: direction predictor with configurable depth, counter width and optional global-history (gshare) indexing.
- Sits beside the fetch-stage PC register. Fetch reads a prediction in the same cycle; the execute stage writes back the resolved outcome.
- Adds behaviour the old table lacked:
  - a synchronous table-initialisation sweep;
  - saturating N-bit counters;
  - a speculative global history register with mispredict repair.

---
 rtl/bp_pkg.sv | 35 +++
 rtl/bp_sat_counter_array.sv | 40 ++++
 rtl/branch_predictor_table.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch direction predictor:
// FSM state encoding, saturating counter step and index hashing.
package bp_pkg;

  localparam int IDX_MAX = 16;
  localparam int CTR_MAX = 4;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } bp_state_e;

  // Step an up/down counter by one, clamping at 0 and 2^ctr_bits-1.
  function automatic logic [CTR_MAX-1:0] sat_next(
    input logic [CTR_MAX-1:0] ctr,
    input logic               taken,
    input int                 ctr_bits
  );
    logic [CTR_MAX-1:0] max_val;
    max_val = CTR_MAX'((1 << ctr_bits) - 1);
    if (taken) begin
      return (ctr >= max_val) ? max_val : ctr + CTR_MAX'(1);
    end
    return (ctr == '0) ? '0 : ctr - CTR_MAX'(1);
  endfunction

  // gshare hash; callers zero-extend both operands and truncate the result.
  function automatic logic [IDX_MAX-1:0] bp_hash(
    input logic [IDX_MAX-1:0] pc_idx,
    input logic [IDX_MAX-1:0] ghr
  );
    return pc_idx ^ ghr;
  endfunction

endpackage

// File: rtl/bp_sat_counter_array.sv
// Saturating-counter storage: one write port (init value or +/-1 step of the
// addressed entry) and one combinational read port for fetch.
module bp_sat_counter_array
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int CTR_BITS   = 2,
  parameter int INIT_CTR   = 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic                  wr_init,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_taken,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [CTR_BITS-1:0]   rd_ctr
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic [CTR_BITS-1:0] mem_reg [DEPTH];
  logic [CTR_BITS-1:0] wr_data;

  always_comb begin
    wr_data = CTR_BITS'(INIT_CTR);
    if (!wr_init) begin
      wr_data = CTR_BITS'(sat_next(CTR_MAX'(mem_reg[wr_idx]), wr_taken, CTR_BITS));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_idx] <= wr_data;
    end
  end

  // Fetch needs the prediction in the same cycle, so no read register here.
  assign rd_ctr = mem_reg[rd_idx];

endmodule

// File: rtl/branch_predictor_table.sv
// Direction predictor: init sweep FSM, optional gshare global history with
// speculative shift and mispredict repair, around a saturating counter array.
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 0,
  parameter int INIT_CTR   = 1
) (
  input  logic                                   clk,
  input  logic                                   srst,
  output logic                                   ready,
  input  logic                                   pred_req,
  input  logic [INDEX_BITS-1:0]                  pred_pc_idx,
  output logic                                   prediction,
  output logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0] pred_ghr,
  input  logic                                   upd_valid,
  input  logic [INDEX_BITS-1:0]                  upd_pc_idx,
  input  logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0] upd_ghr,
  input  logic                                   upd_taken,
  input  logic                                   upd_mispredict
);

  bp_state_e             state_reg, state_next;
  logic [INDEX_BITS-1:0] init_ptr_reg;
  logic [INDEX_BITS-1:0] rd_idx, upd_idx, arr_wr_idx;
  logic [CTR_BITS-1:0]   rd_ctr;
  logic                  active, raw_pred, upd_en, arr_wr_en, arr_wr_init;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg    <= ST_INIT;
      init_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_INIT) begin
        init_ptr_reg <= init_ptr_reg + INDEX_BITS'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_INIT && (&init_ptr_reg)) begin
      state_next = ST_RUN;
    end
  end

  // Every output is forced low until the sweep has finished.
  assign active     = (state_reg == ST_RUN) && !srst;
  assign ready      = active;
  assign raw_pred   = rd_ctr[CTR_BITS-1];
  assign prediction = active & raw_pred;
  assign upd_en     = active & upd_valid;

  assign arr_wr_init = (state_reg == ST_INIT);
  assign arr_wr_en   = (!srst && arr_wr_init) || upd_en;
  assign arr_wr_idx  = arr_wr_init ? init_ptr_reg : upd_idx;

  generate
    if (GHR_BITS == 0) begin : g_bimodal
      logic unused_sigs;
      assign unused_sigs = ^{upd_ghr, upd_mispredict, pred_req};
      assign rd_idx   = pred_pc_idx;
      assign upd_idx  = upd_pc_idx;
      assign pred_ghr = '0;
    end else begin : g_gshare
      logic [GHR_BITS-1:0] ghr_reg, ghr_next, repair_val, spec_val;
      logic                unused_ghr_msb;

      assign unused_ghr_msb = upd_ghr[GHR_BITS-1];
      assign rd_idx  = INDEX_BITS'(bp_hash(IDX_MAX'(pred_pc_idx), IDX_MAX'(ghr_reg)));
      assign upd_idx = INDEX_BITS'(bp_hash(IDX_MAX'(upd_pc_idx), IDX_MAX'(upd_ghr)));

      if (GHR_BITS == 1) begin : g_one
        assign repair_val = upd_taken;
        assign spec_val   = raw_pred;
      end else begin : g_many
        assign repair_val = {upd_ghr[GHR_BITS-2:0], upd_taken};
        assign spec_val   = {ghr_reg[GHR_BITS-2:0], raw_pred};
      end

      // A mispredict repair overrides whatever fetch speculated this cycle.
      always_comb begin
        ghr_next = ghr_reg;
        if (upd_en && upd_mispredict) begin
          ghr_next = repair_val;
        end else if (active && pred_req) begin
          ghr_next = spec_val;
        end
      end

      always_ff @(posedge clk) begin
        if (srst) begin
          ghr_reg <= '0;
        end else begin
          ghr_reg <= ghr_next;
        end
      end

      assign pred_ghr = active ? ghr_reg : '0;
    end
  endgenerate

  bp_sat_counter_array #(
    .INDEX_BITS (INDEX_BITS),
    .CTR_BITS   (CTR_BITS),
    .INIT_CTR   (INIT_CTR)
  ) u_array (
    .clk      (clk),
    .wr_en    (arr_wr_en),
    .wr_init  (arr_wr_init),
    .wr_idx   (arr_wr_idx),
    .wr_taken (upd_taken),
    .rd_idx   (rd_idx),
    .rd_ctr   (rd_ctr)
  );

endmodule
